// File: rtl/subleq_phase_seq_pkg.sv
// Shared SUBLEQ sequencer definitions: phase names and default memory wait mask.
package subleq_pkg;

   // Phase numbering of the standard 8-phase SUBLEQ instruction.
   typedef enum logic [3:0] {
      PH_IDLE = 4'd0,
      PH_ROP0 = 4'd1,
      PH_ROP1 = 4'd2,
      PH_ROP2 = 4'd3,
      PH_RMD0 = 4'd4,
      PH_RMD1 = 4'd5,
      PH_SUB  = 4'd6,
      PH_WBMD = 4'd7
   } phase_e;

   // Returns the wait-mask bit belonging to one phase.
   function automatic logic [15:0] wait_bit(phase_e p);
      return 16'd1 << p;
   endfunction

   // Memory-data reads are the only phases that stall on mem_rdy by default.
   localparam logic [15:0] DEF_WAIT_MASK = wait_bit(PH_RMD0) | wait_bit(PH_RMD1);

endpackage

// File: rtl/subleq_phase_seq_if.sv
// Control/status bundle between the SUBLEQ phase sequencer and its controller.
interface subleq_phase_seq_if #(
   parameter int unsigned NPHASE = 8,
   parameter int unsigned ICNT_W = 16
);
   localparam int unsigned PH_W = $clog2(NPHASE);

   logic              run;
   logic              step;
   logic              halt_req;
   logic              mem_rdy;
   logic              cnt_clr;
   logic [NPHASE-1:0] phase_oh;
   logic [PH_W-1:0]   phase_idx;
   logic              busy;
   logic              inst_done;
   logic [ICNT_W-1:0] inst_cnt;

   modport master (
      output run, step, halt_req, mem_rdy, cnt_clr,
      input  phase_oh, phase_idx, busy, inst_done, inst_cnt
   );

   modport slave (
      input  run, step, halt_req, mem_rdy, cnt_clr,
      output phase_oh, phase_idx, busy, inst_done, inst_cnt
   );
endinterface

// File: rtl/subleq_phase_seq_dec.sv
// Binary index to one-hot decoder; indices >= N produce an all-zero vector.
module subleq_onehot_dec #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [W-1:0] idx,
   output logic [N-1:0] oh
);

   // Compare the index against every legal position.
   always_comb begin
      oh = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx == W'(i)) oh[i] = 1'b1;
      end
   end

endmodule

// File: rtl/subleq_phase_seq.sv
// SUBLEQ phase sequencer: steps through NPHASE-1 active phases per instruction,
// stalling on mem_rdy in masked phases and counting retired instructions.
module subleq_phase_seq
   import subleq_pkg::*;
#(
   parameter int unsigned NPHASE    = 8,
   parameter logic [15:0] WAIT_MASK = DEF_WAIT_MASK,
   parameter int unsigned ICNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   subleq_phase_seq_if.slave  bus
);

   localparam int unsigned     PH_W    = $clog2(NPHASE);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE - 1);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

   logic [PH_W-1:0]   phase_q;
   logic [PH_W-1:0]   phase_d;
   logic [ICNT_W-1:0] cnt_q;
   logic [3:0]        ph_ext;
   logic              start;
   logic              advance;
   logic              done_c;

   // Next-phase selection; the last phase loops straight to phase 1 while running.
   always_comb begin
      ph_ext  = 4'(phase_q);
      start   = (bus.run | bus.step) & ~bus.halt_req;
      advance = ~WAIT_MASK[ph_ext] | bus.mem_rdy;
      done_c  = 1'b0;
      phase_d = phase_q;
      if (phase_q == '0) begin
         if (start) phase_d = PH_ONE;
      end else if (advance) begin
         if (phase_q == PH_LAST) begin
            done_c  = 1'b1;
            phase_d = (bus.run & ~bus.halt_req) ? PH_ONE : '0;
         end else begin
            phase_d = phase_q + PH_ONE;
         end
      end
   end

   // Phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase_q <= '0;
      else        phase_q <= phase_d;
   end

   // Retired-instruction counter; a clear beats a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           cnt_q <= '0;
      else if (bus.cnt_clr) cnt_q <= '0;
      else if (done_c)      cnt_q <= cnt_q + ICNT_W'(1);
   end

   subleq_onehot_dec #(.N(NPHASE), .W(PH_W)) u_dec (
      .idx (phase_q),
      .oh  (bus.phase_oh)
   );

   assign bus.phase_idx = phase_q;
   assign bus.busy      = |phase_q;
   assign bus.inst_done = done_c;
   assign bus.inst_cnt  = cnt_q;

endmodule
